// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: function codes, FSM states
// and the instruction field layout with small field-extraction helpers.
package alu_issue_ctrl_pkg;

   typedef enum logic [2:0] {
      FN_ADI = 3'b000,
      FN_ADD = 3'b001,
      FN_SUB = 3'b010,
      FN_AND = 3'b011,
      FN_OR  = 3'b100,
      FN_XOR = 3'b101,
      FN_LSL = 3'b110,
      FN_LSR = 3'b111
   } alu_func_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_e;

   localparam int INSTR_W  = 16;
   localparam int NOP_BIT  = 15;
   localparam int FUNC_MSB = 14;
   localparam int FUNC_LSB = 12;
   localparam int RD_MSB   = 11;
   localparam int RD_LSB   = 8;
   localparam int IMM_MSB  = 7;
   localparam int NIB_MSB  = 3;

   function automatic logic instr_is_nop(input logic [INSTR_W-1:0] ins);
      return ins[NOP_BIT];
   endfunction

   function automatic alu_func_e instr_func(input logic [INSTR_W-1:0] ins);
      return alu_func_e'(ins[FUNC_MSB:FUNC_LSB]);
   endfunction

   function automatic logic [3:0] instr_rd(input logic [INSTR_W-1:0] ins);
      return ins[RD_MSB:RD_LSB];
   endfunction

   function automatic logic [7:0] instr_imm(input logic [INSTR_W-1:0] ins);
      return ins[IMM_MSB:0];
   endfunction

   function automatic logic [3:0] instr_nib(input logic [INSTR_W-1:0] ins);
      return ins[NIB_MSB:0];
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction issue handshake between an instruction producer (master) and
// the issue controller (slave), plus the retire pulse.
interface alu_issue_ctrl_if;
   import alu_issue_ctrl_pkg::*;

   logic [INSTR_W-1:0] instr_i;
   logic               instr_valid_i;
   logic               instr_ready_o;
   logic               done_o;

   modport master (output instr_i, output instr_valid_i, input instr_ready_o, input done_o);
   modport slave  (input instr_i, input instr_valid_i, output instr_ready_o, output done_o);
endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// 16x8 register file: async-reset clear, two combinational read ports
// (internal operand fetch and debug) and one synchronous write port.
module alu_issue_ctrl_regfile #(
   parameter int         NREGS     = 16,
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       we,
   input  logic [3:0] waddr,
   input  logic [7:0] wdata,
   input  logic [3:0] raddr,
   output logic [7:0] rdata,
   input  logic [3:0] dbg_addr,
   output logic [7:0] dbg_data
);

   logic [7:0] mem [NREGS];

   // Per-entry flops so every register can be cleared by the async reset.
   for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            mem[gi] <= RESET_VAL;
         end else if (we && (waddr == 4'(gi))) begin
            mem[gi] <= wdata;
         end
      end
   end

   assign rdata    = mem[raddr];
   assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle execute controller: accepts an instruction, fetches operand B,
// drives the external ALU, captures its result and writes it back.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int         NREGS     = 16,
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   alu_issue_ctrl_if.slave       instr_bus,
   output logic [7:0]            alu_a_imm_o,
   output logic [3:0]            alu_a_mem_o,
   output logic [7:0]            alu_b_o,
   output logic [2:0]            alu_func_o,
   input  logic [7:0]            alu_result_i,
   input  logic                  alu_fz_i,
   input  logic                  alu_fc_i,
   output logic                  fz_o,
   output logic                  fc_o,
   input  logic [3:0]            dbg_addr_i,
   output logic [7:0]            dbg_data_o
);

   state_e             state_reg, state_next;
   logic [INSTR_W-1:0] instr_reg;
   logic [7:0]         b_reg, res_reg;
   logic               fz_cand_reg, fc_cand_reg;
   logic               fz_reg, fc_reg;
   logic               wb_write;
   logic [7:0]         rd_data;

   alu_issue_ctrl_regfile #(
      .NREGS     (NREGS),
      .RESET_VAL (RESET_VAL)
   ) u_regfile (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .we       (wb_write),
      .waddr    (instr_rd(instr_reg)),
      .wdata    (res_reg),
      .raddr    (instr_rd(instr_reg)),
      .rdata    (rd_data),
      .dbg_addr (dbg_addr_i),
      .dbg_data (dbg_data_o)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg   <= ST_IDLE;
         instr_reg   <= '0;
         b_reg       <= '0;
         res_reg     <= '0;
         fz_cand_reg <= 1'b0;
         fc_cand_reg <= 1'b0;
         fz_reg      <= 1'b0;
         fc_reg      <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == ST_IDLE && instr_bus.instr_valid_i) begin
            instr_reg <= instr_bus.instr_i;
         end
         if (state_reg == ST_READ) begin
            b_reg <= rd_data;
         end
         if (state_reg == ST_EXEC) begin
            res_reg     <= alu_result_i;
            fz_cand_reg <= alu_fz_i;
            fc_cand_reg <= alu_fc_i;
         end
         if (wb_write) begin
            fz_reg <= fz_cand_reg;
            fc_reg <= fc_cand_reg;
         end
      end
   end

   always_comb begin
      state_next              = state_reg;
      instr_bus.instr_ready_o = 1'b0;
      instr_bus.done_o        = 1'b0;
      wb_write                = 1'b0;
      alu_func_o              = '0;
      alu_a_imm_o             = '0;
      alu_a_mem_o             = '0;
      alu_b_o                 = '0;
      // Operand/function lines stay quiet while idle; the ALU picks A itself.
      if (state_reg != ST_IDLE) begin
         alu_func_o  = instr_func(instr_reg);
         alu_a_imm_o = instr_imm(instr_reg);
         alu_a_mem_o = instr_nib(instr_reg);
      end
      case (state_reg)
         ST_IDLE: begin
            instr_bus.instr_ready_o = 1'b1;
            if (instr_bus.instr_valid_i) begin
               state_next = ST_READ;
            end
         end
         ST_READ: state_next = ST_EXEC;
         ST_EXEC: begin
            alu_b_o    = b_reg;
            state_next = ST_WB;
         end
         ST_WB: begin
            instr_bus.done_o = 1'b1;
            wb_write         = !instr_is_nop(instr_reg);
            state_next       = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign fz_o = fz_reg;
   assign fc_o = fc_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench: directed scenarios plus randomized instructions
// checked against an architectural model of registers and flags.
module tb_alu_issue_ctrl;
   import alu_issue_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] alu_a_imm, alu_b, alu_result, dbg_data;
   logic [3:0] alu_a_mem, dbg_addr;
   logic [2:0] alu_func;
   logic       alu_fz, alu_fc, fz, fc;

   always #5 clk = ~clk;

   alu_issue_ctrl_if bus();

   alu_issue_ctrl #(.NREGS(16), .RESET_VAL(8'h00)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .instr_bus    (bus),
      .alu_a_imm_o  (alu_a_imm),
      .alu_a_mem_o  (alu_a_mem),
      .alu_b_o      (alu_b),
      .alu_func_o   (alu_func),
      .alu_result_i (alu_result),
      .alu_fz_i     (alu_fz),
      .alu_fc_i     (alu_fc),
      .fz_o         (fz),
      .fc_o         (fc),
      .dbg_addr_i   (dbg_addr),
      .dbg_data_o   (dbg_data)
   );

   // Behavioural 8-op ALU: returns {zero, carry, result}.
   function automatic logic [9:0] alu_model(input logic [2:0] f, input logic [7:0] ai,
                                            input logic [3:0] am, input logic [7:0] b);
      logic [8:0] s;
      case (f)
         3'b000:  s = {1'b0, ai} + {1'b0, b};
         3'b001:  s = {5'b0, am} + {1'b0, b};
         3'b010:  s = {5'b0, am} - {1'b0, b};
         3'b011:  s = {1'b0, {4'b0, am} & b};
         3'b100:  s = {1'b0, {4'b0, am} | b};
         3'b101:  s = {1'b0, {4'b0, am} ^ b};
         3'b110:  s = {1'b0, b[6:0], 1'b0};
         default: s = {2'b0, b[7:1]};
      endcase
      return {(s[7:0] == 8'h00), s[8], s[7:0]};
   endfunction

   always_comb {alu_fz, alu_fc, alu_result} = alu_model(alu_func, alu_a_imm, alu_a_mem, alu_b);

   logic [7:0] ref_regs [16];
   logic       ref_fz, ref_fc;
   int         n_cmp = 0;
   int         n_err = 0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mk(input logic nop, input logic [2:0] f,
                                      input logic [3:0] rd, input logic [7:0] imm);
      return {nop, f, rd, imm};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) ref_regs[i] = 8'h00;
      ref_fz = 1'b0;
      ref_fc = 1'b0;
   endtask

   task automatic model_retire(input logic [15:0] ins);
      logic [9:0] r;
      if (!ins[15]) begin
         r = alu_model(ins[14:12], ins[7:0], ins[3:0], ref_regs[ins[11:8]]);
         ref_regs[ins[11:8]] = r[7:0];
         ref_fz = r[9];
         ref_fc = r[8];
      end
   endtask

   task automatic read_reg(input logic [3:0] a, output logic [7:0] v);
      dbg_addr = a;
      #1;
      v = dbg_data;
   endtask

   // One instruction, checked cycle by cycle from accept to the idle cycle after WB.
   task automatic do_instr(input logic [15:0] ins);
      logic [7:0] v;
      @(posedge clk); #1;
      bus.instr_valid_i = 1'b1;
      bus.instr_i = ins;
      check("ready_idle", 16'(bus.instr_ready_o), 16'd1);
      @(posedge clk); #1;
      bus.instr_valid_i = 1'b0;
      check("ready_read", 16'(bus.instr_ready_o), 16'd0);
      check("done_read", 16'(bus.done_o), 16'd0);
      @(posedge clk); #1;
      check("alu_func_exec", 16'(alu_func), 16'(ins[14:12]));
      check("alu_a_imm_exec", 16'(alu_a_imm), 16'(ins[7:0]));
      check("alu_a_mem_exec", 16'(alu_a_mem), 16'(ins[3:0]));
      check("alu_b_exec", 16'(alu_b), 16'(ref_regs[ins[11:8]]));
      @(posedge clk); #1;
      check("done_wb", 16'(bus.done_o), 16'd1);
      model_retire(ins);
      @(posedge clk); #1;
      check("done_after", 16'(bus.done_o), 16'd0);
      check("ready_after", 16'(bus.instr_ready_o), 16'd1);
      read_reg(ins[11:8], v);
      check("reg_rd", 16'(v), 16'(ref_regs[ins[11:8]]));
      check("fz", 16'(fz), 16'(ref_fz));
      check("fc", 16'(fc), 16'(ref_fc));
      $display("instr %h rd=R%0d -> reg=%h fz=%b fc=%b", ins, ins[11:8], v, fz, fc);
   endtask

   initial begin
      logic [7:0]  v;
      logic [15:0] ia, ib;
      bus.instr_valid_i = 1'b0;
      bus.instr_i = '0;
      dbg_addr = '0;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_ready", 16'(bus.instr_ready_o), 16'd1);
      check("rst_done", 16'(bus.done_o), 16'd0);
      check("rst_fz", 16'(fz), 16'd0);
      check("rst_fc", 16'(fc), 16'd0);
      check("rst_alu_out", {alu_func, alu_a_mem, alu_a_imm, 1'b0}, 16'd0);
      for (int i = 0; i < 16; i++) begin
         read_reg(4'(i), v);
         check("rst_reg", 16'(v), 16'h00);
      end
      $display("reset: regs cleared, ready=%b", bus.instr_ready_o);

      // ADI wrap to zero with carry
      do_instr(mk(1'b0, FN_ADI, 4'd3, 8'hFF));
      read_reg(4'd3, v);
      check("r3_ff", 16'(v), 16'h00FF);
      do_instr(mk(1'b0, FN_ADI, 4'd3, 8'h01));
      check("r3_wrap_flags", {14'd0, fz, fc}, 16'b11);

      // SUB with borrow: 1 - 2
      do_instr(mk(1'b0, FN_ADI, 4'd1, 8'h02));
      do_instr(mk(1'b0, FN_SUB, 4'd1, 8'h01));
      read_reg(4'd1, v);
      check("sub_res", 16'(v), 16'h00FF);
      check("sub_flags", {14'd0, fz, fc}, 16'b01);

      // LSL then a NOP-flagged instruction
      do_instr(mk(1'b0, FN_ADI, 4'd2, 8'h81));
      do_instr(mk(1'b0, FN_LSL, 4'd2, 8'h01));
      read_reg(4'd2, v);
      check("lsl_res", 16'(v), 16'h0002);
      do_instr(mk(1'b1, FN_ADI, 4'd2, 8'h55));
      read_reg(4'd2, v);
      check("nop_res", 16'(v), 16'h0002);

      // Valid held high with two queued, dependent instructions
      ia = mk(1'b0, FN_ADI, 4'd4, 8'h05);
      ib = mk(1'b0, FN_ADD, 4'd4, 8'h03);
      @(posedge clk); #1;
      bus.instr_valid_i = 1'b1;
      bus.instr_i = ia;
      check("b2b_ready0", 16'(bus.instr_ready_o), 16'd1);
      for (int c = 1; c <= 9; c++) begin
         @(posedge clk); #1;
         if (c == 1) bus.instr_i = ib;
         if (c == 5) bus.instr_valid_i = 1'b0;
         check("b2b_ready", 16'(bus.instr_ready_o), 16'((c == 4) || (c >= 8)));
         check("b2b_done", 16'(bus.done_o), 16'((c == 3) || (c == 7)));
         if (c == 3) model_retire(ia);
         if (c == 7) model_retire(ib);
         $display("b2b cycle %0d ready=%b done=%b", c, bus.instr_ready_o, bus.done_o);
      end
      read_reg(4'd4, v);
      check("b2b_r4", 16'(v), 16'h0008);
      check("b2b_r4_model", 16'(v), 16'(ref_regs[4]));

      // Randomized instructions
      for (int n = 0; n < 40; n++) begin
         do_instr(mk(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                     4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))));
      end
      for (int i = 0; i < 16; i++) begin
         read_reg(4'(i), v);
         check("rand_reg_sweep", 16'(v), 16'(ref_regs[i]));
      end

      // Reset during EXEC aborts the instruction
      do_instr(mk(1'b0, FN_ADI, 4'd5, 8'h22));
      @(posedge clk); #1;
      bus.instr_valid_i = 1'b1;
      bus.instr_i = mk(1'b0, FN_ADI, 4'd5, 8'h10);
      @(posedge clk); #1;
      bus.instr_valid_i = 1'b0;
      @(posedge clk); #1;
      check("abort_exec_func", 16'(alu_func), 16'(FN_ADI));
      rst_n = 1'b0;
      #1;
      model_reset();
      check("abort_ready", 16'(bus.instr_ready_o), 16'd1);
      check("abort_done", 16'(bus.done_o), 16'd0);
      check("abort_flags", {14'd0, fz, fc}, 16'd0);
      @(posedge clk); #1;
      @(posedge clk); #3;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         check("abort_no_done", 16'(bus.done_o), 16'd0);
         check("abort_idle", 16'(bus.instr_ready_o), 16'd1);
      end
      read_reg(4'd5, v);
      check("abort_r5", 16'(v), 16'(ref_regs[5]));
      check("abort_r5_zero", 16'(v), 16'h0000);
      $display("abort: R5=%h ready=%b", v, bus.instr_ready_o);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
